fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Instruction-fetch stage directly upstream of decode and the immediate extender.
//  Owns the PC and issues word fetches to instruction memory over a valid/ready port.
//  Buffers in-order responses in a DEPTH-entry FIFO and hands {instr, pc} to decode via valid/ready.
//  Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.
// PARAMETERS
//  DEPTH     2             FIFO entries and maximum in-flight + buffered instructions (>=2)
//  RESET_PC  32'h0000_0000 PC loaded at reset (word aligned)
// PORTS
//  clk             in   1   single clock, rising edge
//  reset_n         in   1   asynchronous active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_addr       out  32  fetch address (= pc), bits[1:0] always 0
//  imem_resp_valid in   1   response word valid (in order, >=1 cycle after acceptance)
//  imem_resp_data  in   32  fetched instruction word
//  instr_valid     out  1   buffered instruction available to decode
//  instr_ready     in   1   decode consumes the instruction this cycle
//  instr           out  32  instruction at FIFO head
//  instr_pc        out  32  PC of instruction at FIFO head
//  redirect_valid  in   1   branch/jump taken: restart fetch
//  redirect_pc     in   32  new fetch PC; bits[1:0] ignored (forced to 0)
// BEHAVIOUR
//  State: pc (next fetch), resp_pc (PC of next kept response), count (FIFO occupancy),
//   inflight (accepted, unanswered requests), drop (responses still to discard, drop<=inflight).
//  Reset (async, reset_n=0): pc=resp_pc=RESET_PC, count=inflight=drop=0, FIFO pointers 0;
//   all outputs low/zero while reset_n=0.
//  Request: imem_req_valid = (inflight+count < DEPTH) && !redirect_valid. imem_addr = pc.
//   On accept (valid&&ready): pc <= pc+4 (wraps modulo 2^32); inflight++.
//  Response: inflight--. If drop!=0: drop--, data discarded. Else push {data, resp_pc}; resp_pc += 4.
//   Credit rule guarantees the push never hits a full FIFO.
//  Output: instr_valid = (count!=0) && !redirect_valid; instr/instr_pc = head entry (0 when empty).
//   Pop on instr_valid && instr_ready. Push and pop in the same cycle: count unchanged.
//   Zero-bubble case: response arrives cycle N, instr_valid is high in cycle N+1 (one-cycle latency).
//  Redirect (redirect_valid=1, takes priority over everything):
//   - The FIFO is flushed (count=0, pointers reset). No pop occurs. No request is issued.
//   - pc and resp_pc are both set to {redirect_pc[31:2],2'b00}.
//   - A response arriving in the same cycle is discarded.
//   - inflight <= inflight - resp_valid; drop <= inflight - resp_valid (all in-flight requests become stale).
//   - Back-to-back redirects: the last one wins; each recomputes drop the same way.
//  Counters are $clog2(DEPTH+1) bits wide and never wrap.
//  imem_resp_valid with inflight==0 is a protocol error; it is flagged by an assertion and ignored.
//  Reset mid-operation: all state clears immediately. The memory system is reset together with this
//   block, so no stale responses remain afterwards.
// TESTING
//  1 Reset: reset_n=0 mid-stream -> req_valid=0, instr_valid=0; after release the first imem_addr=RESET_PC.
//  2 Streaming: req_ready=1, 1-cycle response latency, instr_ready=1 -> instr_pc sequence 0,4,8,...
//    After warm-up, one instruction per cycle.
//  3 Backpressure: instr_ready=0 -> exactly DEPTH requests issued, then req_valid=0.
//    Release -> words popped in order, no loss or duplication.
//  4 Redirect with 2 in flight: redirect_pc=0x100 -> both stale responses dropped.
//    The next instr_pc is 0x100, then 0x104.
//  5 Redirect in the same cycle as a response and a pop -> that response is dropped.
//    drop = inflight-1, and the old head is not consumed.
//  6 Redirect to 0xFFFF_FFFC -> the next fetch wraps to 0x0000_0000; redirect_pc=0x103 fetches 0x100.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus bundle: instruction-memory request/response port, the
// decode-side instruction handshake and the branch/jump redirect input.
// The master modport is the fetch_buffer view; slave is the environment view.
interface fetch_buffer_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req_valid,
      output imem_addr,
      output instr_valid,
      output instr,
      output instr_pc,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data,
      output instr_ready,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage. Owns the PC, issues word fetches, buffers in-order
// responses in a DEPTH-entry FIFO and presents {instr, pc} to decode.
// A redirect flushes the FIFO, restarts fetch at the new PC and marks every
// request still in flight as stale so its response is discarded on arrival.
// Credits: requests are only issued while inflight+count < DEPTH, so every
// kept response is guaranteed a free FIFO slot.
module fetch_buffer #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic            clk,
   input logic            reset_n,
   fetch_buffer_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   localparam cnt_t        CNT_ONE    = cnt_t'(1);
   localparam cnt_t        CNT_FULL   = cnt_t'(DEPTH);
   localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

   // FIFO pointer advance with explicit wrap so non-power-of-two depths work
   function automatic ptr_t ptr_next(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Fetch addresses are always word aligned; low bits of a target are dropped
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   // Control state
   logic [31:0] pc;        // next address to request
   logic [31:0] resp_pc;   // PC belonging to the next response we keep
   cnt_t        count;     // FIFO occupancy
   cnt_t        inflight;  // accepted requests not yet answered
   cnt_t        drop;      // stale responses still to be discarded
   ptr_t        wptr;
   ptr_t        rptr;

   // FIFO storage (data only, never reset)
   logic [31:0] fifo_instr [DEPTH];
   logic [31:0] fifo_pc    [DEPTH];

   logic [CW:0] credit_used;
   logic        redir;
   logic        accept;
   logic        resp;
   logic        push;
   logic        pop;
   logic        head_valid;

   assign credit_used = {1'b0, inflight} + {1'b0, count};
   assign redir       = reset_n && bus.redirect_valid;

   // Requests stop while a redirect is pending so no fetch leaves with the old PC
   assign bus.imem_req_valid = reset_n && (credit_used < CREDIT_MAX) && !bus.redirect_valid;
   assign bus.imem_addr      = reset_n ? pc : '0;

   assign head_valid      = reset_n && (count != '0);
   assign bus.instr_valid = head_valid && !bus.redirect_valid;
   assign bus.instr       = head_valid ? fifo_instr[rptr] : '0;
   assign bus.instr_pc    = head_valid ? fifo_pc[rptr]    : '0;

   assign accept = bus.imem_req_valid && bus.imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored
   assign resp   = reset_n && bus.imem_resp_valid && (inflight != '0);
   assign push   = resp && (drop == '0) && !redir;
   assign pop    = bus.instr_valid && bus.instr_ready;

   // PC, occupancy, credit and stale-response bookkeeping; redirect wins over all
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc       <= RESET_PC;
         resp_pc  <= RESET_PC;
         count    <= '0;
         inflight <= '0;
         drop     <= '0;
         wptr     <= '0;
         rptr     <= '0;
      end else if (redir) begin
         // Every request still outstanding after this cycle is stale
         pc       <= word_align(bus.redirect_pc);
         resp_pc  <= word_align(bus.redirect_pc);
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
         inflight <= inflight - cnt_t'(resp);
         drop     <= inflight - cnt_t'(resp);
      end else begin
         if (accept) begin
            pc <= pc + 32'd4;
         end
         if (push) begin
            resp_pc <= resp_pc + 32'd4;
            wptr    <= ptr_next(wptr);
         end
         if (pop) begin
            rptr <= ptr_next(rptr);
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
         if (accept && !resp) begin
            inflight <= inflight + CNT_ONE;
         end else if (resp && !accept) begin
            inflight <= inflight - CNT_ONE;
         end
         if (resp && (drop != '0)) begin
            drop <= drop - CNT_ONE;
         end
      end
   end

   // Capture kept responses together with the PC they were fetched from
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wptr] <= bus.imem_resp_data;
         fifo_pc[wptr]    <= resp_pc;
      end
   end

   a_resp_needs_request: assert property (
      @(posedge clk) disable iff (!reset_n)
      bus.imem_resp_valid |-> (inflight != '0)
   ) else $error("fetch_buffer: imem_resp_valid with no request in flight");

   a_drop_bounded: assert property (
      @(posedge clk) disable iff (!reset_n)
      drop <= inflight
   ) else $error("fetch_buffer: drop exceeds inflight");

   a_push_has_room: assert property (
      @(posedge clk) disable iff (!reset_n)
      push |-> (count != CNT_FULL)
   ) else $error("fetch_buffer: push into a full FIFO");

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=4). A small instruction memory model
// answers accepted requests in order, one cycle later, unless held.
module tb_fetch_buffer;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset_n;

   fetch_buffer_if bus();

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          n_acc  = 0;
   logic        mem_hold;
   logic [31:0] pend [$];
   logic [31:0] got_pc [$];
   logic [31:0] got_instr [$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   // One clock: sample the request handshake, clock, then update the memory model
   task automatic tick();
      logic        acc;
      logic [31:0] acc_addr;
      #1;
      acc      = reset_n && bus.imem_req_valid && bus.imem_req_ready;
      acc_addr = bus.imem_addr;
      @(posedge clk);
      if (acc) begin
         pend.push_back(acc_addr);
         n_acc++;
      end
      @(negedge clk);
      if (!reset_n) begin
         pend.delete();
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = '0;
      end else if (!mem_hold && pend.size() != 0) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = memf(pend.pop_front());
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = '0;
      end
   endtask

   task automatic collect(input int n, input int budget);
      got_pc.delete();
      got_instr.delete();
      for (int c = 0; c < budget && got_pc.size() < n; c++) begin
         #1;
         if (bus.instr_valid && bus.instr_ready) begin
            got_pc.push_back(bus.instr_pc);
            got_instr.push_back(bus.instr);
         end
         tick();
      end
   endtask

   task automatic drain();
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b1;
      mem_hold           = 1'b0;
      repeat (12) tick();
   endtask

   task automatic do_redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
   endtask

   task automatic test_reset();
      reset_n             = 1'b1;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.instr_ready     = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      mem_hold            = 1'b0;
      #1 reset_n = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", bus.instr_pc); end
      repeat (2) tick();
      reset_n = 1'b1;
      #1;
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid: got %b expected 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL release_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
   endtask

   task automatic test_streaming();
      logic [31:0] exp;
      exp = RESET_PC;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      for (int k = 0; k < 24; k++) begin
         if (k == 16) bus.imem_req_ready = 1'b0;
         #1;
         if (k >= 2 && k < 18) begin
            checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid cycle %0d: got %b expected 1", k, bus.instr_valid); end
         end
         if (bus.instr_valid === 1'b1) begin
            checks++;
            if (bus.instr_pc !== exp || bus.instr !== memf(exp)) begin
               errors++; $display("FAIL stream_word: got pc %h instr %h expected pc %h instr %h", bus.instr_pc, bus.instr, exp, memf(exp));
            end
            exp = exp + 32'd4;
         end
         tick();
      end
      checks++; if (exp !== 32'd64) begin errors++; $display("FAIL stream_total: got next pc %h expected 00000040", exp); end
   endtask

   task automatic test_backpressure();
      drain();
      bus.instr_ready = 1'b0;
      do_redirect(32'h200);
      n_acc = 0;
      bus.imem_req_ready = 1'b1;
      repeat (10) tick();
      #1;
      checks++; if (n_acc != DEPTH) begin errors++; $display("FAIL bp_requests: got %0d expected %0d", n_acc, DEPTH); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", bus.imem_req_valid); end
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200) begin errors++; $display("FAIL bp_head: got valid %b pc %h expected 1 00000200", bus.instr_valid, bus.instr_pc); end
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (i < DEPTH) begin
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 + 32'(4 * i) || bus.instr !== memf(32'h200 + 32'(4 * i))) begin
               errors++; $display("FAIL bp_release %0d: got valid %b pc %h expected 1 %h", i, bus.instr_valid, bus.instr_pc, 32'h200 + 32'(4 * i));
            end
         end else if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty %0d: got valid %b expected 0", i, bus.instr_valid);
         end
         tick();
      end
   endtask

   task automatic test_redirect_inflight();
      drain();
      n_acc = 0;
      mem_hold           = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      tick();
      tick();
      checks++; if (n_acc != 2) begin errors++; $display("FAIL rd2_inflight: got %0d expected 2", n_acc); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      #1;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd2_no_req: got %b expected 0", bus.imem_req_valid); end
      tick();
      bus.redirect_valid = 1'b0;
      mem_hold           = 1'b0;
      checks++; if (n_acc != 2) begin errors++; $display("FAIL rd2_req_count: got %0d expected 2", n_acc); end
      collect(2, 20);
      checks++;
      if (got_pc.size() < 2) begin
         errors++; $display("FAIL rd2_timeout: got %0d words expected 2", got_pc.size());
      end else if (got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104 || got_instr[0] !== memf(32'h100) || got_instr[1] !== memf(32'h104)) begin
         errors++; $display("FAIL rd2_sequence: got pc %h %h expected 00000100 00000104", got_pc[0], got_pc[1]);
      end
   endtask

   task automatic test_redirect_resp_pop();
      drain();
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b0;
      do_redirect(32'h300);
      mem_hold           = 1'b1;
      bus.imem_req_ready = 1'b1;
      repeat (3) tick();
      bus.imem_req_ready = 1'b0;
      mem_hold           = 1'b0;
      tick();
      tick();
      #1;
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h300) begin errors++; $display("FAIL rdp_head: got valid %b pc %h expected 1 00000300", bus.instr_valid, bus.instr_pc); end
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h400;
      #1;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rdp_masked: got %b expected 0", bus.instr_valid); end
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rdp_flushed: got %b expected 0", bus.instr_valid); end
      tick();
      #1;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rdp_stale_kept: got valid %b pc %h expected 0", bus.instr_valid, bus.instr_pc); end
      bus.imem_req_ready = 1'b1;
      collect(1, 20);
      checks++;
      if (got_pc.size() < 1) begin
         errors++; $display("FAIL rdp_timeout: got 0 words expected 1");
      end else if (got_pc[0] !== 32'h400 || got_instr[0] !== memf(32'h400)) begin
         errors++; $display("FAIL rdp_first: got pc %h instr %h expected 00000400 %h", got_pc[0], got_instr[0], memf(32'h400));
      end
   endtask

   task automatic test_wrap();
      drain();
      do_redirect(32'hFFFF_FFFC);
      #1;
      checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", bus.imem_addr); end
      bus.imem_req_ready = 1'b1;
      tick();
      #1;
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 00000000", bus.imem_addr); end
      collect(2, 20);
      checks++;
      if (got_pc.size() < 2) begin
         errors++; $display("FAIL wrap_timeout: got %0d words expected 2", got_pc.size());
      end else if (got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0 || got_instr[1] !== memf(32'h0)) begin
         errors++; $display("FAIL wrap_sequence: got pc %h %h expected fffffffc 00000000", got_pc[0], got_pc[1]);
      end
      drain();
      do_redirect(32'h103);
      #1;
      checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL align_addr: got %h expected 00000100", bus.imem_addr); end
      bus.imem_req_ready = 1'b1;
      collect(1, 20);
      checks++;
      if (got_pc.size() < 1) begin
         errors++; $display("FAIL align_timeout: got 0 words expected 1");
      end else if (got_pc[0] !== 32'h100 || got_instr[0] !== memf(32'h100)) begin
         errors++; $display("FAIL align_first: got pc %h expected 00000100", got_pc[0]);
      end
   endtask

   task automatic test_reset_midstream();
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b0;
      mem_hold           = 1'b0;
      repeat (3) tick();
      #1;
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", bus.instr_valid); end
      reset_n = 1'b0;
      #1;
      checks++; if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got req %b instr %b expected 0 0", bus.imem_req_valid, bus.instr_valid); end
      checks++; if (bus.instr !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_data: got instr %h addr %h expected 0 0", bus.instr, bus.imem_addr); end
      tick();
      reset_n = 1'b1;
      #1;
      checks++; if (bus.imem_addr !== RESET_PC || bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL mid_release: got addr %h req %b expected %h 1", bus.imem_addr, bus.imem_req_valid, RESET_PC); end
      bus.instr_ready = 1'b1;
      collect(2, 20);
      checks++;
      if (got_pc.size() < 2) begin
         errors++; $display("FAIL mid_timeout: got %0d words expected 2", got_pc.size());
      end else if (got_pc[0] !== RESET_PC || got_pc[1] !== RESET_PC + 32'd4) begin
         errors++; $display("FAIL mid_sequence: got pc %h %h expected %h %h", got_pc[0], got_pc[1], RESET_PC, RESET_PC + 32'd4);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_resp_pop();
      test_wrap();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
